// File: rtl/wbq_pkg.sv
// Shared types and constants for the register-file writeback queue.
// The entry type fixes the data/index widths that the queue stores.
package wbq_pkg;
  localparam int WBQ_DEPTH  = 4;
  localparam int WBQ_DATA_W = 32;
  localparam int WBQ_ADDR_W = 4;

  localparam logic [WBQ_ADDR_W-1:0] REG_PC = 4'hF;

  typedef struct packed {
    logic                  valid;
    logic [WBQ_ADDR_W-1:0] rd;
    logic [WBQ_DATA_W-1:0] data;
  } wbq_entry_t;
endpackage

// File: rtl/wbq_fifo.sv
// Circular in-order storage for writeback entries: two ordered pushes
// (a older than b) and one pop per cycle.
module wbq_fifo
  import wbq_pkg::*;
#(
  parameter  int DEPTH = WBQ_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_a,
  input  logic [WBQ_ADDR_W-1:0] a_rd,
  input  logic [WBQ_DATA_W-1:0] a_data,
  input  logic                  push_b,
  input  logic [WBQ_ADDR_W-1:0] b_rd,
  input  logic [WBQ_DATA_W-1:0] b_data,
  input  logic                  pop,
  output wbq_entry_t            head_ent,
  output logic [PTR_W-1:0]      head,
  output logic [CNT_W-1:0]      count,
  output wbq_entry_t            ents [DEPTH]
);

  logic                  vld_q  [DEPTH];
  logic [WBQ_ADDR_W-1:0] rd_q   [DEPTH];
  logic [WBQ_DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]      tail;
  logic [PTR_W-1:0]      tail_b;

  // push_b is only ever asserted together with push_a, so b lands behind a
  assign tail_b = tail + PTR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) vld_q[i] <= 1'b0;
    end else begin
      if (pop) begin
        vld_q[head] <= 1'b0;
        head        <= head + PTR_W'(1);
      end
      if (push_a) vld_q[tail]   <= 1'b1;
      if (push_b) vld_q[tail_b] <= 1'b1;
      tail  <= tail + PTR_W'(push_a) + PTR_W'(push_b);
      count <= count + CNT_W'(push_a) + CNT_W'(push_b) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push_a) begin
      rd_q[tail]   <= a_rd;
      data_q[tail] <= a_data;
    end
    if (push_b) begin
      rd_q[tail_b]   <= b_rd;
      data_q[tail_b] <= b_data;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ents[i].valid = vld_q[i];
      ents[i].rd    = rd_q[i];
      ents[i].data  = data_q[i];
    end
  end

  assign head_ent = ents[head];

endmodule

// File: rtl/rf_writeback_queue.sv
// Writeback queue feeding the register file write port (we3/ra3/wd3), with
// PC redirection, pending scoreboard and optional forwarding (WBQ_FWD_EN).
module rf_writeback_queue
  import wbq_pkg::*;
#(
  parameter int DEPTH  = WBQ_DEPTH,
  parameter int DATA_W = WBQ_DATA_W,
  parameter int ADDR_W = WBQ_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ld_valid,
  input  logic [ADDR_W-1:0]    ld_rd,
  input  logic [DATA_W-1:0]    ld_data,
  output logic                 ld_ready,
  input  logic                 alu_valid,
  input  logic [ADDR_W-1:0]    alu_rd,
  input  logic [DATA_W-1:0]    alu_data,
  output logic                 alu_ready,
  output logic                 we3,
  output logic [ADDR_W-1:0]    ra3,
  output logic [DATA_W-1:0]    wd3,
  output logic                 pc_we,
  output logic [DATA_W-1:0]    pc_wd,
  output logic [2**ADDR_W-1:0] pending,
  input  logic [ADDR_W-1:0]    fwd_ra,
  output logic                 fwd_hit,
  output logic [DATA_W-1:0]    fwd_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  wbq_entry_t       head_ent;
  wbq_entry_t       ents [DEPTH];
  logic [PTR_W-1:0] head;
  logic [CNT_W-1:0] count;
  logic             ld_acc;
  logic             alu_acc;
  logic             push_a;
  logic             push_b;
  logic [ADDR_W-1:0] a_rd;
  logic [DATA_W-1:0] a_data;
  logic             pop;

  // Readiness looks only at the registered count; the load claims a slot first
  assign ld_ready  = ({1'b0, count} < (CNT_W+1)'(DEPTH));
  assign ld_acc    = ld_valid & ld_ready;
  assign alu_ready = (({1'b0, count} + (CNT_W+1)'(ld_acc)) < (CNT_W+1)'(DEPTH));
  assign alu_acc   = alu_valid & alu_ready;

  assign push_a = ld_acc | alu_acc;
  assign push_b = ld_acc & alu_acc;
  assign a_rd   = ld_acc ? ld_rd   : alu_rd;
  assign a_data = ld_acc ? ld_data : alu_data;
  assign pop    = head_ent.valid;

  wbq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_a   (push_a),
    .a_rd     (a_rd),
    .a_data   (a_data),
    .push_b   (push_b),
    .b_rd     (alu_rd),
    .b_data   (alu_data),
    .pop      (pop),
    .head_ent (head_ent),
    .head     (head),
    .count    (count),
    .ents     (ents)
  );

  // Drain stage: head entry goes to the register file or the PC strobe
  always_comb begin
    we3   = 1'b0;
    ra3   = '0;
    wd3   = '0;
    pc_we = 1'b0;
    pc_wd = '0;
    if (head_ent.valid) begin
      if (head_ent.rd == REG_PC) begin
        pc_we = 1'b1;
        pc_wd = head_ent.data;
      end else begin
        we3 = 1'b1;
        ra3 = head_ent.rd;
        wd3 = head_ent.data;
      end
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++)
      if (ents[i].valid) pending[ents[i].rd] = 1'b1;
  end

`ifdef WBQ_FWD_EN
  // Walk oldest to youngest so the last match is the youngest value
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ents[PTR_W'(head + PTR_W'(i))].valid &&
          ents[PTR_W'(head + PTR_W'(i))].rd == fwd_ra) begin
        fwd_hit  = 1'b1;
        fwd_data = ents[PTR_W'(head + PTR_W'(i))].data;
      end
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_ra, head};
  assign fwd_hit    = 1'b0;
  assign fwd_data   = '0;
`endif

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Bench for rf_writeback_queue: directed and random steps checked against a
// queue-based reference model.
module tb_rf_writeback_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_valid = 1'b0;
  logic [3:0]  ld_rd = '0;
  logic [31:0] ld_data = '0;
  logic        ld_ready;
  logic        alu_valid = 1'b0;
  logic [3:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        alu_ready;
  logic        we3;
  logic [3:0]  ra3;
  logic [31:0] wd3;
  logic        pc_we;
  logic [31:0] pc_wd;
  logic [15:0] pending;
  logic [3:0]  fwd_ra = '0;
  logic        fwd_hit;
  logic [31:0] fwd_data;

  rf_writeback_queue #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .we3(we3), .ra3(ra3), .wd3(wd3), .pc_we(pc_we), .pc_wd(pc_wd),
    .pending(pending), .fwd_ra(fwd_ra), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  rd;
    logic [31:0] d;
  } ent_t;

  ent_t q[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".we3"}, 64'(we3), 64'd0);
    chk({tag, ".ra3"}, 64'(ra3), 64'd0);
    chk({tag, ".wd3"}, 64'(wd3), 64'd0);
    chk({tag, ".pc_we"}, 64'(pc_we), 64'd0);
    chk({tag, ".pc_wd"}, 64'(pc_wd), 64'd0);
    chk({tag, ".pending"}, 64'(pending), 64'd0);
    chk({tag, ".fwd_hit"}, 64'(fwd_hit), 64'd0);
    chk({tag, ".fwd_data"}, 64'(fwd_data), 64'd0);
  endtask

  // One cycle: drive inputs, compare against the model, then advance the model
  task automatic step(input string tag, input bit lv, input logic [3:0] lr, input logic [31:0] lw,
                      input bit av, input logic [3:0] ar, input logic [31:0] aw,
                      input logic [3:0] fr);
    int          sz;
    bit          e_ldr, e_alur, e_we, e_pcwe, e_hit;
    logic [3:0]  e_ra;
    logic [31:0] e_wd, e_pcwd, e_fd;
    logic [15:0] e_pend;
    @(negedge clk);
    ld_valid = lv; ld_rd = lr; ld_data = lw;
    alu_valid = av; alu_rd = ar; alu_data = aw;
    fwd_ra = fr;
    #1;
    sz     = q.size();
    e_ldr  = (sz < DEPTH);
    e_alur = ((sz + ((lv && e_ldr) ? 1 : 0)) < DEPTH);
    e_we = 0; e_pcwe = 0; e_ra = '0; e_wd = '0; e_pcwd = '0;
    if (sz > 0) begin
      if (q[0].rd == 4'd15) begin e_pcwe = 1; e_pcwd = q[0].d; end
      else begin e_we = 1; e_ra = q[0].rd; e_wd = q[0].d; end
    end
    e_pend = '0;
    e_hit = 0; e_fd = '0;
    for (int i = 0; i < sz; i++) begin
      e_pend[q[i].rd] = 1'b1;
`ifdef WBQ_FWD_EN
      if (q[i].rd == fr) begin e_hit = 1; e_fd = q[i].d; end
`endif
    end
    chk({tag, ".ld_ready"}, 64'(ld_ready), 64'(e_ldr));
    chk({tag, ".alu_ready"}, 64'(alu_ready), 64'(e_alur));
    chk({tag, ".we3"}, 64'(we3), 64'(e_we));
    chk({tag, ".ra3"}, 64'(ra3), 64'(e_ra));
    chk({tag, ".wd3"}, 64'(wd3), 64'(e_wd));
    chk({tag, ".pc_we"}, 64'(pc_we), 64'(e_pcwe));
    chk({tag, ".pc_wd"}, 64'(pc_wd), 64'(e_pcwd));
    chk({tag, ".pending"}, 64'(pending), 64'(e_pend));
    chk({tag, ".fwd_hit"}, 64'(fwd_hit), 64'(e_hit));
    chk({tag, ".fwd_data"}, 64'(fwd_data), 64'(e_fd));
    @(posedge clk);
    if (sz > 0) void'(q.pop_front());
    if (lv && e_ldr) q.push_back('{rd: lr, d: lw});
    if (av && e_alur) q.push_back('{rd: ar, d: aw});
  endtask

  task automatic idle(input string tag, input int n, input logic [3:0] fr);
    for (int i = 0; i < n; i++) step(tag, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0, fr);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset.ld_ready", 64'(ld_ready), 64'd1);
    chk("reset.alu_ready", 64'(alu_ready), 64'd1);

    // Single ALU write
    step("alu1", 0, 4'd0, 32'd0, 1, 4'd3, 32'h0000_00AA, 4'd0);
    idle("alu1_drain", 2, 4'd0);

    // Same-cycle load and ALU, load is older
    step("dual", 1, 4'd5, 32'h11, 1, 4'd6, 32'h22, 4'd0);
    idle("dual_drain", 3, 4'd0);

    // Saturate with both producers valid
    for (int i = 0; i < 6; i++)
      step("fill", 1, 4'($urandom_range(0, 14)), $urandom, 1, 4'($urandom_range(0, 14)), $urandom, 4'd0);
    step("fill_alu", 0, 4'd0, 32'd0, 1, 4'd9, 32'h99, 4'd0);
    idle("fill_drain", 5, 4'd0);

    // PC redirect
    step("pc", 0, 4'd0, 32'd0, 1, 4'd15, 32'h0000_0100, 4'd15);
    idle("pc_drain", 2, 4'd15);

    // Two writes to r2; youngest must forward
    step("fwd", 1, 4'd2, 32'h10, 1, 4'd2, 32'h20, 4'd2);
    idle("fwd_drain", 3, 4'd2);

    // Random traffic
    for (int i = 0; i < 300; i++)
      step("rand", bit'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
           bit'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
           4'($urandom_range(0, 15)));
    idle("rand_drain", 5, 4'd0);

    // Reset mid-drain with three entries queued
    step("pre_rst", 1, 4'd1, 32'hA1, 1, 4'd4, 32'hA4, 4'd4);
    step("pre_rst", 1, 4'd7, 32'hA7, 1, 4'd8, 32'hA8, 4'd4);
    chk("pre_rst.depth", 64'(q.size()), 64'd3);
    @(negedge clk);
    ld_valid = 1'b0; alu_valid = 1'b0; fwd_ra = 4'd4;
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    chk_idle_outputs("mid_rst");
    @(posedge clk);
    #1;
    chk("mid_rst.we3_edge", 64'(we3), 64'd0);
    chk("mid_rst.pending_edge", 64'(pending), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst.ld_ready", 64'(ld_ready), 64'd1);
    chk("post_rst.alu_ready", 64'(alu_ready), 64'd1);
    chk("post_rst.we3", 64'(we3), 64'd0);
    idle("post_rst", 2, 4'd4);
    step("post_rst_push", 1, 4'd12, 32'hC0DE, 0, 4'd0, 32'd0, 4'd12);
    idle("post_rst_drain", 2, 4'd12);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/rf_writeback_queue.md
Name: rf_writeback_queue

Overview:
- Write-side companion of the three-ported register file. Accepts results from two producers: the single-cycle ALU path and the multi-cycle load unit.
- Buffers results in a small in-order queue and drains one entry per cycle onto the register file's single write port (we3/ra3/wd3).
- Destination 15 (PC) is never written to the register file. It is redirected to a PC-write strobe.
- Exports a pending-destination scoreboard for hazard stalls, plus a forwarding lookup.

Parameters:
- DEPTH, 4, queue entries (power of two, 2..16)
- DATA_W, 32, result data width
- ADDR_W, 4, register index width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ld_valid  in  1  load unit result valid
- ld_rd  in  ADDR_W  load destination register
- ld_data  in  DATA_W  load result
- ld_ready  out  1  load result accepted this cycle when high with ld_valid
- alu_valid  in  1  ALU result valid
- alu_rd  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- alu_ready  out  1  ALU result accepted this cycle when high with alu_valid
- we3  out  1  register file write enable
- ra3  out  ADDR_W  register file write address
- wd3  out  DATA_W  register file write data
- pc_we  out  1  PC write strobe (entry destination 15)
- pc_wd  out  DATA_W  PC write data
- pending  out  2**ADDR_W  bit r high = a queued write to register r exists
- fwd_ra  in  ADDR_W  forwarding query register
- fwd_hit  out  1  queued value for fwd_ra exists
- fwd_data  out  DATA_W  youngest queued value for fwd_ra

Behaviour:
- Reset (async, rst_n low):
  - all entries invalid, head = tail = count = 0
  - we3 = 0, ra3 = 0, wd3 = 0, pc_we = 0, pc_wd = 0, pending = 0, fwd_hit = 0, fwd_data = 0
  - ld_ready = 1 and alu_ready = 1 once rst_n is high
- Acceptance (combinational from registered count; a same-cycle pop does not free a slot for a same-cycle push):
  - ld_ready = (count < DEPTH)
  - alu_ready = (count + (ld_valid & ld_ready) < DEPTH)
  - The load always wins the last free slot.
- Ordering: when both are pushed in the same cycle, the load entry is enqueued first (older), the ALU entry second.
- Drain: head entry valid drives outputs combinationally in the cycle after its push edge. It is popped at the next rising edge. Latency is push edge N -> register file write at edge N+1. Throughput is 1 entry per cycle.
- Head destination != 15: we3 = 1, ra3 = rd, wd3 = data, pc_we = 0.
- Head destination == 15: we3 = 0, pc_we = 1, pc_wd = data. ra3 and wd3 hold 0.
- Empty queue: we3 = 0, pc_we = 0, ra3 = 0, wd3 = 0.
- Count update: count_next = count + pushes − pop. Range 0..DEPTH, never overflows (guaranteed by ready rules). Pointers wrap modulo DEPTH.
- pending: OR over valid entries of onehot(rd), including the head being drained this cycle. Bit 15 reflects queued PC writes.
- Multiple queued writes to the same register are all performed in order. No coalescing.
- Reset mid-drain: queued entries are discarded and no write is issued.

Optional Feature:
- Macro: WBQ_FWD_EN
- Defined:
  - fwd_hit = 1 if any valid entry has rd == fwd_ra.
  - fwd_data = data of the youngest such entry (closest to tail).
  - Purely combinational over queue contents.
- Undefined:
  - fwd_hit = 0 and fwd_data = 0 constantly.
  - Consumers stall on pending instead.

Decomposition:
- Package wbq_pkg:
  - typedef wbq_entry_t {valid, rd[ADDR_W-1:0], data[DATA_W-1:0]}
  - constant REG_PC = 4'hF
  - default DEPTH
- Sub-module wbq_fifo:
  - circular storage of wbq_entry_t with dual push (ordered) and single pop
  - exposes head entry, count, and the full entry array for the pending/forwarding logic
- rf_writeback_queue owns the ready arbitration, the drain/PC split, the scoreboard, and the forwarding logic.

Test Plan:
- ALU push rd=3, data=0x0000_00AA at edge 0, idle after -> cycle 1: we3=1, ra3=3, wd3=0xAA, pending[3]=1; cycle 2: we3=0, pending=0.
- Same cycle: ld rd=5 data=0x11 plus alu rd=6 data=0x22 -> cycle 1 writes r5=0x11, cycle 2 writes r6=0x22.
- Fill to count=3 (DEPTH=4) and hold with continuous ld_valid and alu_valid -> ld_ready=1, alu_ready=0; load accepted, ALU stalled until a slot frees.
- Push rd=15 data=0x0000_0100 -> we3=0, pc_we=1, pc_wd=0x100 for one cycle; pending[15]=1 until popped.
- With WBQ_FWD_EN: queue r2=0x10 then r2=0x20, fwd_ra=2 -> fwd_hit=1, fwd_data=0x20. Without the macro, fwd_hit=0.
- Three entries queued, rst_n pulsed low mid-cycle -> outputs zero immediately, no further we3; after release, count=0 and both ready signals high.
